// File: rtl/hazard_pkg.sv
// Shared constants and the in-flight entry layout for the hazard scoreboard.
package hazard_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam int unsigned CAUSE_REGA   = 0;
  localparam int unsigned CAUSE_REGB   = 1;
  localparam int unsigned CAUSE_MEM    = 2;
  localparam int unsigned CAUSE_BRANCH = 3;
  localparam int unsigned CAUSE_W      = 4;

  // Entry fields are sized for the widest supported configuration; narrower
  // indices and addresses are zero-extended on the way in.
  localparam int unsigned SB_REG_W = 8;
  localparam int unsigned SB_MEM_W = 32;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] dest;
    logic [SB_MEM_W-1:0] mem_dest;
    logic                is_branch;
    logic                is_load;
  } sb_entry_t;

  function automatic logic is_branch_op(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JALR) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one key against DEPTH enabled entries; a zero key never matches.
module hazard_match #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned W     = 5
) (
  input  logic [W-1:0]       i_key,
  input  logic [DEPTH*W-1:0] i_vec,
  input  logic [DEPTH-1:0]   i_en,
  output logic               o_hit_c
);

  always_comb begin
    o_hit_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_en[i] && (i_vec[i*W +: W] == i_key)) o_hit_c = 1'b1;
    end
    if (i_key == '0) o_hit_c = 1'b0;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue hazard scoreboard: register/memory RAW and branch-shadow stalls.
// Define FORWARD_EN to limit register hazards to load-use against entry 0.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH         = 3,
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned MEM_AW        = 20,
  parameter int unsigned BRANCH_SHADOW = 3,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [REG_AW-1:0]          reg_src_a,
  input  logic [REG_AW-1:0]          reg_src_b,
  input  logic [REG_AW-1:0]          reg_dest,
  input  logic [MEM_AW-1:0]          mem_src,
  input  logic [MEM_AW-1:0]          mem_dest,
  input  logic [6:0]                 opcode,
  input  logic                       flush,
  output logic                       stall,
  output logic [CAUSE_W-1:0]         stall_cause,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  sb_entry_t              r_q [DEPTH];
  logic [CNT_W-1:0]       r_cnt;

  logic [DEPTH*SB_REG_W-1:0] w_dest_vec;
  logic [DEPTH*SB_MEM_W-1:0] w_mdest_vec;
  logic [DEPTH-1:0]          w_valid;
  logic [DEPTH-1:0]          w_branch;
  logic [DEPTH-1:0]          w_reg_en;
  logic                      w_hit_a;
  logic                      w_hit_b;
  logic                      w_hit_mem;
  logic                      w_hit_br;
  logic                      w_hazard;
  logic                      w_accept;
  sb_entry_t                 w_new;
  logic [OCC_W-1:0]          w_occ;

  // Flatten the queue for the comparators.
  always_comb begin
    w_dest_vec  = '0;
    w_mdest_vec = '0;
    w_valid     = '0;
    w_branch    = '0;
    w_occ       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_dest_vec[i*SB_REG_W +: SB_REG_W]  = r_q[i].dest;
      w_mdest_vec[i*SB_MEM_W +: SB_MEM_W] = r_q[i].mem_dest;
      w_valid[i]  = r_q[i].valid;
      w_branch[i] = r_q[i].is_branch;
      w_occ       = w_occ + OCC_W'(r_q[i].valid);
    end
  end

  always_comb begin
    w_reg_en = '0;
`ifdef FORWARD_EN
    w_reg_en[0] = r_q[0].valid && r_q[0].is_load;
`else
    w_reg_en = w_valid;
`endif
  end

  hazard_match #(.DEPTH(DEPTH), .W(SB_REG_W)) u_match_a (
    .i_key(SB_REG_W'(reg_src_a)), .i_vec(w_dest_vec), .i_en(w_reg_en), .o_hit_c(w_hit_a)
  );
  hazard_match #(.DEPTH(DEPTH), .W(SB_REG_W)) u_match_b (
    .i_key(SB_REG_W'(reg_src_b)), .i_vec(w_dest_vec), .i_en(w_reg_en), .o_hit_c(w_hit_b)
  );
  hazard_match #(.DEPTH(DEPTH), .W(SB_MEM_W)) u_match_mem (
    .i_key(SB_MEM_W'(mem_src)), .i_vec(w_mdest_vec), .i_en(w_valid), .o_hit_c(w_hit_mem)
  );

  always_comb begin
    w_hit_br    = |(w_valid[BRANCH_SHADOW-1:0] & w_branch[BRANCH_SHADOW-1:0]);
    w_hazard    = w_hit_a || w_hit_b || w_hit_mem || w_hit_br;
    issue_ready = !rst && !flush && !w_hazard;
    stall       = issue_valid && !issue_ready;
    w_accept    = issue_valid && issue_ready;
    stall_cause = '0;
    if (stall && !rst) begin
      stall_cause[CAUSE_REGA]   = w_hit_a;
      stall_cause[CAUSE_REGB]   = w_hit_b;
      stall_cause[CAUSE_MEM]    = w_hit_mem;
      stall_cause[CAUSE_BRANCH] = w_hit_br;
    end
    w_new           = '0;
    w_new.valid     = 1'b1;
    w_new.dest      = SB_REG_W'(reg_dest);
    w_new.mem_dest  = SB_MEM_W'(mem_dest);
    w_new.is_branch = is_branch_op(opcode);
    w_new.is_load   = (opcode == OP_LOAD);
    occupancy       = w_occ;
    stall_cycles    = r_cnt;
  end

  // Queue shifts every cycle; a stalled or empty slot enters as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_cnt <= '0;
    end else begin
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= '0;
      end else begin
        for (int unsigned i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
        r_q[0] <= w_accept ? w_new : '0;
      end
      if (stall && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: directed plan sequences plus random stimulus against a queue-based model.
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int BS    = 3;
  localparam bit [6:0] ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst, issue_valid, flush;
  logic [4:0]  reg_src_a, reg_src_b, reg_dest;
  logic [19:0] mem_src, mem_dest;
  logic [6:0]  opcode;
  wire         issue_ready, stall, issue_ready4, stall4;
  wire [3:0]   stall_cause, stall_cause4;
  wire [1:0]   occupancy, occupancy4;
  wire [31:0]  stall_cycles;
  wire [3:0]   stall_cycles4;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .reg_src_a(reg_src_a), .reg_src_b(reg_src_b), .reg_dest(reg_dest),
    .mem_src(mem_src), .mem_dest(mem_dest), .opcode(opcode), .flush(flush),
    .stall(stall), .stall_cause(stall_cause), .occupancy(occupancy),
    .stall_cycles(stall_cycles)
  );

  hazard_scoreboard #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready4),
    .reg_src_a(reg_src_a), .reg_src_b(reg_src_b), .reg_dest(reg_dest),
    .mem_src(mem_src), .mem_dest(mem_dest), .opcode(opcode), .flush(flush),
    .stall(stall4), .stall_cause(stall_cause4), .occupancy(occupancy4),
    .stall_cycles(stall_cycles4)
  );

  typedef struct {
    bit     chk;
    bit     ready;
    bit     stl;
    bit [3:0] cause;
    int     occ;
    longint cnt;
    int     cnt4;
  } exp_t;

  typedef struct {
    bit v;
    int dest;
    int mdest;
    bit br;
    bit ld;
  } ment_t;

  exp_t   exp_q[$];
  ment_t  mq[$];
  bit     m_known = 0;
  longint m_cnt = 0;
  int     m_cnt4 = 0;
  int     n_pass = 0;
  int     n_chk  = 0;
  bit     done   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit reg_hit(input int key);
    if (key == 0) return 0;
`ifdef FORWARD_EN
    return mq[0].v && mq[0].ld && (mq[0].dest == key);
`else
    foreach (mq[i]) if (mq[i].v && mq[i].dest == key) return 1;
    return 0;
`endif
  endfunction

  function automatic bit mem_hit(input int key);
    if (key == 0) return 0;
    foreach (mq[i]) if (mq[i].v && mq[i].mdest == key) return 1;
    return 0;
  endfunction

  function automatic bit br_hit();
    for (int i = 0; i < BS; i++) if (mq[i].v && mq[i].br) return 1;
    return 0;
  endfunction

  // Drive one cycle, record what the outputs must show, then advance the model.
  task automatic step(input bit iv, input int a, input int b, input int d,
                      input int ms, input int md, input bit [6:0] op,
                      input bit fl, input bit rs);
    exp_t  e;
    ment_t n;
    bit ra, rb, hm, hb;
    @(negedge clk);
    issue_valid = iv; reg_src_a = 5'(a); reg_src_b = 5'(b); reg_dest = 5'(d);
    mem_src = 20'(ms); mem_dest = 20'(md); opcode = op; flush = fl; rst = rs;
    e.chk = m_known;
    ra = m_known && reg_hit(a);
    rb = m_known && reg_hit(b);
    hm = m_known && mem_hit(ms);
    hb = m_known && br_hit();
    e.ready = !rs && !fl && !(ra || rb || hm || hb);
    e.stl   = iv && !e.ready;
    e.cause = (e.stl && !rs) ? {hb, hm, rb, ra} : 4'b0;
    e.occ   = 0;
    foreach (mq[i]) if (mq[i].v) e.occ++;
    e.cnt   = m_cnt;
    e.cnt4  = m_cnt4;
    exp_q.push_back(e);
    n = '{v: 0, dest: 0, mdest: 0, br: 0, ld: 0};
    if (rs) begin
      mq = {};
      for (int i = 0; i < DEPTH; i++) mq.push_back(n);
      m_cnt = 0; m_cnt4 = 0; m_known = 1;
    end else begin
      if (e.stl) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (fl) begin
        foreach (mq[i]) mq[i] = n;
      end else begin
        if (iv && e.ready) begin
          n.v = 1; n.dest = d; n.mdest = md;
          n.br = (op == 7'b1100011) || (op == 7'b1100111) || (op == 7'b1101111);
          n.ld = (op == 7'b0000011);
        end
        mq.push_front(n);
        void'(mq.pop_back());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, ALU, 0, 0);
  endtask

  // Monitor: compares the DUT against each recorded expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("issue_ready", 64'(issue_ready), 64'(e.ready));
          check("stall", 64'(stall), 64'(e.stl));
          check("stall_cause", 64'(stall_cause), 64'(e.cause));
          check("occupancy", 64'(occupancy), 64'(e.occ));
          check("stall_cycles", 64'(stall_cycles), 64'(e.cnt));
          check("stall_cycles_w4", 64'(stall_cycles4), 64'(e.cnt4));
        end
      end
    end
  end

  initial begin
    int ms, md;
    bit [6:0] op;
    rst = 1; issue_valid = 0; flush = 0; reg_src_a = 0; reg_src_b = 0; reg_dest = 0;
    mem_src = 0; mem_dest = 0; opcode = ALU;
    step(0, 0, 0, 0, 0, 0, ALU, 0, 1);
    step(1, 0, 0, 0, 0, 0, ALU, 0, 1);
    // Register RAW on x5
    step(1, 0, 0, 5, 0, 0, ALU, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 5, 0, 0, 0, 0, ALU, 0, 0);
    idle(3);
    // x0 never creates a dependence
    step(1, 0, 0, 0, 0, 0, ALU, 0, 0);
    step(1, 0, 0, 0, 0, 0, ALU, 0, 0);
    idle(3);
    // Memory RAW, then a neighbouring address
    step(1, 0, 0, 0, 0, 'h123, ALU, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 'h123, 0, ALU, 0, 0);
    step(1, 0, 0, 0, 'h124, 0, ALU, 0, 0);
    idle(3);
    // Branch shadow with flush on second stall cycle
    step(1, 0, 0, 0, 0, 0, 7'b1100011, 0, 0);
    step(1, 0, 0, 0, 0, 0, ALU, 0, 0);
    step(1, 0, 0, 0, 0, 0, ALU, 1, 0);
    step(1, 0, 0, 0, 0, 0, ALU, 0, 0);
    idle(3);
    // Reset during a stall
    for (int i = 0; i < 3; i++) step(1, 0, 0, 5, 0, 0, ALU, 0, 0);
    step(1, 5, 0, 0, 0, 0, ALU, 0, 0);
    step(1, 5, 0, 0, 0, 0, ALU, 0, 1);
    step(0, 0, 0, 0, 0, 0, ALU, 0, 0);
    step(1, 5, 0, 0, 0, 0, ALU, 0, 0);
    idle(3);
    // Load-use versus ALU producer
    step(1, 0, 0, 7, 0, 0, 7'b0000011, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 7, 0, 0, 0, 0, ALU, 0, 0);
    step(1, 0, 0, 7, 0, 0, ALU, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 7, 0, 0, 0, ALU, 0, 0);
    idle(3);
    // Enough branch stalls to saturate the 4-bit counter
    for (int k = 0; k < 7; k++) begin
      step(1, 0, 0, 0, 0, 0, 7'b1101111, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, ALU, 0, 0);
    end
    idle(2);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0: op = 7'b1100011;
        1: op = 7'b1100111;
        2: op = 7'b1101111;
        3, 4, 5: op = 7'b0000011;
        default: op = ALU;
      endcase
      ms = ($urandom_range(0, 2) == 0) ? 0 : 'h120 + int'($urandom_range(0, 5));
      md = ($urandom_range(0, 2) == 0) ? 0 : 'h120 + int'($urandom_range(0, 5));
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), ms, md, op, $urandom_range(0, 19) == 0,
           $urandom_range(0, 79) == 0);
    end
    idle(4);
    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
